// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment width and the active-high hex glyph table.
// Glyph bit order is {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] GLYPH_TBL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nibble);
    return GLYPH_TBL[nibble];
  endfunction

endpackage

// File: rtl/seg7_glyph_rom.sv
// Hex nibble to active-high seven-segment glyph; purely combinational, no handshake.
module seg7_glyph_rom
  import seg7_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] glyph
);

  assign glyph = hex_to_seg(nibble);

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed seven-segment scanner: tear-free frame-boundary value commit, de-ghost gap, LZ suppression.
// Outputs registered one cycle behind the scan state; load is a strobe with no backpressure (last load wins).
module seven_seg_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int SEG_ACT_LOW = 1,
  parameter int DIG_ACT_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_in,
  input  logic                    lz_en,
  output logic [SEG_W-1:0]        seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    update_ack,
  output logic                    frame_tick
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VAL_W = 4 * NUM_DIGITS;

  localparam logic             SEG_POL  = (SEG_ACT_LOW != 0);
  localparam logic             DIG_POL  = (DIG_ACT_LOW != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      slot_cnt;
  logic [IDX_W-1:0]      dig_idx;
  logic [VAL_W-1:0]      pend_val;
  logic [NUM_DIGITS-1:0] pend_dp;
  logic                  pend_vld;
  logic [VAL_W-1:0]      disp_val;
  logic [NUM_DIGITS-1:0] disp_dp;

  logic                  slot_wrap;
  logic                  frame_wrap;
  logic [3:0]            cur_nibble;
  logic                  cur_dp;
  logic                  cur_zero;
  logic [NUM_DIGITS-1:0] zmask;
  logic [NUM_DIGITS-1:0] sel_onehot;
  logic                  zero_run;
  logic [SEG_W-1:0]      cur_glyph;
  logic                  suppress;

  assign slot_wrap  = (slot_cnt == CNT_LAST);
  assign frame_wrap = slot_wrap && (dig_idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      dig_idx  <= '0;
    end else if (slot_wrap) begin
      slot_cnt <= '0;
      dig_idx  <= (dig_idx == IDX_LAST) ? '0 : dig_idx + IDX_W'(1);
    end else begin
      slot_cnt <= slot_cnt + CNT_W'(1);
    end
  end

  // A load landing on the boundary cycle stays pending; the older pending value is what commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_vld   <= 1'b0;
      disp_val   <= '0;
      disp_dp    <= '0;
      update_ack <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      if (frame_wrap && pend_vld) begin
        disp_val <= pend_val;
        disp_dp  <= pend_dp;
      end
      if (load) begin
        pend_val <= value_in;
        pend_dp  <= dp_in;
        pend_vld <= 1'b1;
      end else if (frame_wrap) begin
        pend_vld <= 1'b0;
      end
      update_ack <= frame_wrap && pend_vld;
      frame_tick <= frame_wrap;
    end
  end

  // zmask[k]: every nibble from the top digit down to k is zero.
  always_comb begin
    zmask    = '0;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run && (disp_val[4*k +: 4] == 4'h0);
      zmask[k] = zero_run;
    end
  end

  always_comb begin
    cur_nibble = 4'h0;
    cur_dp     = 1'b0;
    cur_zero   = 1'b0;
    sel_onehot = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (dig_idx == IDX_W'(k)) begin
        cur_nibble    = disp_val[4*k +: 4];
        cur_dp        = disp_dp[k];
        cur_zero      = zmask[k];
        sel_onehot[k] = 1'b1;
      end
    end
  end

  seg7_glyph_rom u_glyph_rom (
    .nibble (cur_nibble),
    .glyph  (cur_glyph)
  );

  assign suppress = lz_en && (dig_idx != '0) && cur_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out  <= {SEG_W{SEG_POL}};
      dp_out   <= SEG_POL;
      digit_en <= {NUM_DIGITS{DIG_POL}};
    end else if (blank_in) begin
      seg_out  <= {SEG_W{SEG_POL}};
      dp_out   <= SEG_POL;
      digit_en <= {NUM_DIGITS{DIG_POL}};
    end else begin
      seg_out  <= (suppress ? {SEG_W{1'b0}} : cur_glyph) ^ {SEG_W{SEG_POL}};
      dp_out   <= cur_dp ^ SEG_POL;
      digit_en <= ((slot_cnt == '0) ? {NUM_DIGITS{1'b0}} : sel_onehot) ^ {NUM_DIGITS{DIG_POL}};
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver with a 4-digit bank and 4-clock slots.
module tb_seven_seg_scan_driver;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        blank_in;
  logic        lz_en;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  digit_en;
  logic        update_ack;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;

  logic [6:0] fr_seg [4];
  logic       fr_dp  [4];
  logic [3:0] fr_en  [4];
  logic [3:0] fr_gap [4];
  logic [6:0] exp_seg [4];
  logic [3:0] en_sel [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  seven_seg_scan_driver #(
    .NUM_DIGITS (4),
    .SCAN_DIV   (4),
    .SEG_ACT_LOW(1),
    .DIG_ACT_LOW(1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .value_in   (value_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .lz_en      (lz_en),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .digit_en   (digit_en),
    .update_ack (update_ack),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (update_ack === 1'b1) ack_cnt++;

  task automatic wait_frame(output logic ack);
    bit found;
    found = 0;
    ack = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) begin
        found = 1;
        ack = update_ack;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL frame_tick_timeout: no frame_tick seen within 40 clks");
    end
  endtask

  // Starts on the negedge where frame_tick is seen; ends 14 negedges later.
  task automatic capture_frame;
    for (int d = 0; d < 4; d++) begin
      @(negedge clk);
      fr_gap[d] = digit_en;
      @(negedge clk);
      fr_seg[d] = seg_out;
      fr_dp[d]  = dp_out;
      fr_en[d]  = digit_en;
      if (d < 3) repeat (2) @(negedge clk);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
    value_in = v;
    dp_in    = dp;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  task automatic test_reset;
    logic ack;
    int   n;
    repeat (3) @(negedge clk);
    checks++; if (seg_out !== 7'h7F) begin errors++; $display("FAIL rst_seg: got %b want %b", seg_out, 7'h7F); end
    checks++; if (dp_out !== 1'b1) begin errors++; $display("FAIL rst_dp: got %b want 1", dp_out); end
    checks++; if (digit_en !== 4'hF) begin errors++; $display("FAIL rst_digit_en: got %b want 1111", digit_en); end
    checks++; if (update_ack !== 1'b0 || frame_tick !== 1'b0) begin
      errors++; $display("FAIL rst_pulses: got ack=%b tick=%b want 0 0", update_ack, frame_tick);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (digit_en !== 4'hF || seg_out !== 7'b1000000) begin
      errors++; $display("FAIL rel_first: got en=%b seg=%b want 1111 1000000", digit_en, seg_out);
    end
    @(negedge clk);
    checks++; if (digit_en !== 4'b1110) begin errors++; $display("FAIL rel_digit0: got %b want 1110", digit_en); end
    wait_frame(ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rst_no_ack: got %b want 0", ack); end
    capture_frame();
    for (int d = 0; d < 4; d++) begin
      checks++; if (fr_en[d] !== en_sel[d]) begin errors++; $display("FAIL scan_en d%0d: got %b want %b", d, fr_en[d], en_sel[d]); end
      checks++; if (fr_gap[d] !== 4'hF) begin errors++; $display("FAIL scan_gap d%0d: got %b want 1111", d, fr_gap[d]); end
      checks++; if (fr_seg[d] !== 7'b1000000) begin errors++; $display("FAIL rst_glyph d%0d: got %b want 1000000", d, fr_seg[d]); end
    end
    wait_frame(ack);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_tick !== 1'b1 && n < 40);
    checks++; if (n != 16) begin errors++; $display("FAIL frame_period: got %0d want 16", n); end
  endtask

  task automatic test_load;
    logic ack;
    wait_frame(ack);
    repeat (4) @(negedge clk);
    do_load(16'h1A3F, 4'b0000);
    repeat (5) @(negedge clk);
    checks++; if (seg_out !== 7'b1000000 || digit_en !== 4'b1011) begin
      errors++; $display("FAIL load_no_tear: got seg=%b en=%b want 1000000 1011", seg_out, digit_en);
    end
    wait_frame(ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL load_ack: got %b want 1", ack); end
    capture_frame();
    exp_seg = '{7'b0001110, 7'b0110000, 7'b0001000, 7'b1111001};
    for (int d = 0; d < 4; d++) begin
      checks++; if (fr_seg[d] !== exp_seg[d]) begin errors++; $display("FAIL load_glyph d%0d: got %b want %b", d, fr_seg[d], exp_seg[d]); end
    end
  endtask

  task automatic test_lz;
    logic ack;
    lz_en = 1'b1;
    do_load(16'h0040, 4'b0000);
    wait_frame(ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL lz_ack: got %b want 1", ack); end
    capture_frame();
    exp_seg = '{7'b1000000, 7'b0011001, 7'b1111111, 7'b1111111};
    for (int d = 0; d < 4; d++) begin
      checks++; if (fr_seg[d] !== exp_seg[d]) begin errors++; $display("FAIL lz_0040 d%0d: got %b want %b", d, fr_seg[d], exp_seg[d]); end
    end
    do_load(16'h0000, 4'b0000);
    wait_frame(ack);
    capture_frame();
    exp_seg = '{7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111};
    for (int d = 0; d < 4; d++) begin
      checks++; if (fr_seg[d] !== exp_seg[d]) begin errors++; $display("FAIL lz_0000 d%0d: got %b want %b", d, fr_seg[d], exp_seg[d]); end
      checks++; if (fr_en[d] !== en_sel[d]) begin errors++; $display("FAIL lz_en_scan d%0d: got %b want %b", d, fr_en[d], en_sel[d]); end
    end
    lz_en = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic ack;
    int   a0;
    #1 a0 = ack_cnt;
    wait_frame(ack);
    do_load(16'h1111, 4'b0000);
    repeat (3) @(negedge clk);
    do_load(16'h2222, 4'b0000);
    repeat (10) @(negedge clk);
    do_load(16'h3333, 4'b0000);
    checks++; if (frame_tick !== 1'b1 || update_ack !== 1'b1) begin
      errors++; $display("FAIL b2b_boundary: got tick=%b ack=%b want 1 1", frame_tick, update_ack);
    end
    capture_frame();
    for (int d = 0; d < 4; d++) begin
      checks++; if (fr_seg[d] !== 7'b0100100) begin errors++; $display("FAIL b2b_last_wins d%0d: got %b want 0100100", d, fr_seg[d]); end
    end
    wait_frame(ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL b2b_held_ack: got %b want 1", ack); end
    capture_frame();
    for (int d = 0; d < 4; d++) begin
      checks++; if (fr_seg[d] !== 7'b0110000) begin errors++; $display("FAIL b2b_held d%0d: got %b want 0110000", d, fr_seg[d]); end
    end
    wait_frame(ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL b2b_idle_ack: got %b want 0", ack); end
    #1;
    checks++; if (ack_cnt - a0 != 2) begin errors++; $display("FAIL b2b_ack_count: got %0d want 2", ack_cnt - a0); end
  endtask

  task automatic test_dp_blank;
    logic ack;
    int   n;
    do_load(16'h3333, 4'b0100);
    wait_frame(ack);
    capture_frame();
    for (int d = 0; d < 4; d++) begin
      checks++; if (fr_dp[d] !== (d != 2)) begin errors++; $display("FAIL dp d%0d: got %b want %b", d, fr_dp[d], (d != 2)); end
    end
    wait_frame(ack);
    @(negedge clk);
    blank_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (seg_out !== 7'h7F || dp_out !== 1'b1 || digit_en !== 4'hF) begin
        errors++; $display("FAIL blank c%0d: got seg=%b dp=%b en=%b want 1111111 1 1111", i, seg_out, dp_out, digit_en);
      end
    end
    blank_in = 1'b0;
    @(negedge clk);
    checks++; if (digit_en !== 4'b1101 || seg_out !== 7'b0110000 || dp_out !== 1'b1) begin
      errors++; $display("FAIL unblank: got en=%b seg=%b dp=%b want 1101 0110000 1", digit_en, seg_out, dp_out);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_tick !== 1'b1 && n < 40);
    checks++; if (n != 9) begin errors++; $display("FAIL blank_phase: got %0d want 9", n); end
  endtask

  task automatic test_reset_mid;
    logic ack;
    int   a0;
    do_load(16'h5555, 4'b1111);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (seg_out !== 7'h7F || dp_out !== 1'b1 || digit_en !== 4'hF) begin
      errors++; $display("FAIL midrst_outs: got seg=%b dp=%b en=%b want 1111111 1 1111", seg_out, dp_out, digit_en);
    end
    checks++; if (update_ack !== 1'b0 || frame_tick !== 1'b0) begin
      errors++; $display("FAIL midrst_pulses: got ack=%b tick=%b want 0 0", update_ack, frame_tick);
    end
    a0 = ack_cnt;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (digit_en !== 4'b1110) begin errors++; $display("FAIL midrst_digit0: got %b want 1110", digit_en); end
    wait_frame(ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL midrst_ack: got %b want 0", ack); end
    capture_frame();
    for (int d = 0; d < 4; d++) begin
      checks++; if (fr_seg[d] !== 7'b1000000 || fr_dp[d] !== 1'b1) begin
        errors++; $display("FAIL midrst_disp d%0d: got seg=%b dp=%b want 1000000 1", d, fr_seg[d], fr_dp[d]);
      end
    end
    #1;
    checks++; if (ack_cnt != a0) begin errors++; $display("FAIL midrst_ack_count: got %0d want %0d", ack_cnt, a0); end
  endtask

  initial begin
    rst_n    = 1'b0;
    load     = 1'b0;
    value_in = 16'h0000;
    dp_in    = 4'b0000;
    blank_in = 1'b0;
    lz_en    = 1'b0;
    test_reset();
    test_load();
    test_lz();
    test_back_to_back();
    test_dp_blank();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
